mips_multicycle_ctrl: RTL

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl_pkg.sv | 46 ++++
 rtl/mips_multicycle_ctrl_outdec.sv | 105 ++++++++++
 rtl/mips_multicycle_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcodes
// and the select/ALU encodings driven onto the datapath.
package mips_multicycle_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_DECODE   = 4'd2;
    localparam state_t ST_MEMADR   = 4'd3;
    localparam state_t ST_MEMRD    = 4'd4;
    localparam state_t ST_MEMWB    = 4'd5;
    localparam state_t ST_MEMWR    = 4'd6;
    localparam state_t ST_EXEC     = 4'd7;
    localparam state_t ST_ALUWB    = 4'd8;
    localparam state_t ST_BRANCH   = 4'd9;
    localparam state_t ST_JUMP     = 4'd10;
    localparam state_t ST_ADDIEXEC = 4'd11;
    localparam state_t ST_ADDIWB   = 4'd12;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Combinational output decoder: turns the current controller state (plus the
// memory handshake and opcode where they qualify a strobe) into datapath controls.
module mips_ctrl_outdec
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic [5:0] op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state)
            ST_FETCH: begin
                // PC+4 and IR load commit only on the cycle memory returns data
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b  = SRCB_IMMSH;
                alu_op     = ALUOP_ADD;
                illegal_op = !is_legal_op(op);
            end
            ST_MEMADR, ST_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            ST_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register and next-state logic; all
// datapath controls come from the mips_ctrl_outdec decoder.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       IllegalOp
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:     state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (Op)
                    OP_R:         state_nxt = ST_EXEC;
                    OP_LW, OP_SW: state_nxt = ST_MEMADR;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_J:         state_nxt = ST_JUMP;
                    OP_ADDI:      state_nxt = ST_ADDIEXEC;
                    default:      state_nxt = ST_FETCH;
                endcase
            end
            ST_MEMADR:   state_nxt = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:    state_nxt = MemReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:    state_nxt = ST_FETCH;
            ST_MEMWR:    state_nxt = MemReady ? ST_FETCH : ST_MEMWR;
            ST_EXEC:     state_nxt = ST_ALUWB;
            ST_ALUWB:    state_nxt = ST_FETCH;
            ST_BRANCH:   state_nxt = ST_FETCH;
            ST_JUMP:     state_nxt = ST_FETCH;
            ST_ADDIEXEC: state_nxt = ST_ADDIWB;
            ST_ADDIWB:   state_nxt = ST_FETCH;
            // unreachable codes recover through IDLE
            default:     state_nxt = ST_IDLE;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state         (state),
        .mem_ready     (MemReady),
        .op            (Op),
        .pc_write      (PCWrite),
        .pc_write_cond (PCWriteCond),
        .i_or_d        (IorD),
        .mem_read      (MemRead),
        .mem_write     (MemWrite),
        .ir_write      (IRWrite),
        .mem_to_reg    (MemtoReg),
        .reg_dst       (RegDst),
        .reg_write     (RegWrite),
        .alu_src_a     (ALUSrcA),
        .alu_src_b     (ALUSrcB),
        .alu_op        (ALUOp),
        .pc_source     (PCSource),
        .instr_done    (InstrDone),
        .illegal_op    (IllegalOp)
    );

endmodule
